// File: rtl/bcmp_pipe_if.sv
// Branch-resolution bus between the execute-stage operand muxes and the
// branch unit.
//   master : drives in_valid, funct3, a_val, b_val, pred_taken, stall, flush,
//            cnt_clr; receives the result and the perf counters.
//   slave  : the branch unit; receives the branch and drives
//            out_valid, br_eq, br_lt, taken, mispredict, illegal,
//            br_count, mispred_count.
interface bcmp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             pred_taken;
  logic             stall;
  logic             flush;
  logic             cnt_clr;
  logic             out_valid;
  logic             br_eq;
  logic             br_lt;
  logic             taken;
  logic             mispredict;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output in_valid, funct3, a_val, b_val, pred_taken, stall, flush, cnt_clr,
    input  out_valid, br_eq, br_lt, taken, mispredict, illegal,
           br_count, mispred_count
  );

  modport slave (
    input  in_valid, funct3, a_val, b_val, pred_taken, stall, flush, cnt_clr,
    output out_valid, br_eq, br_lt, taken, mispredict, illegal,
           br_count, mispred_count
  );
endinterface

// File: rtl/bcmp_pipe.sv
// Branch-resolution unit: decodes the branch funct3 (BEQ/BNE/BLT/BGE/BLTU/
// BGEU), resolves the condition, optionally registers the result behind a
// stall/flush handshake, flags mispredicts against the fetch prediction and
// keeps saturating retired-branch / mispredict counters.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - bcmp_pipe_if.slave: branch inputs, stall/flush/cnt_clr controls,
//          result flags and perf counters
// Parameters: WIDTH operand width, REG_OUT 1 = latency 1 / 0 = combinational,
//             CNT_W perf counter width.
module bcmp_pipe #(
  parameter int WIDTH   = 32,
  parameter int REG_OUT = 1,
  parameter int CNT_W   = 32
) (
  input logic         clk,
  input logic         rst,
  bcmp_pipe_if.slave  bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: compare and decode straight from the operand muxes
  logic signed [WIDTH-1:0] a_s_p0;
  logic signed [WIDTH-1:0] b_s_p0;
  logic                    eq_p0;
  logic                    lt_p0;
  logic                    legal_p0;
  logic                    taken_p0;

  assign a_s_p0 = bus.a_val;
  assign b_s_p0 = bus.b_val;

  always_comb begin
    eq_p0    = (bus.a_val == bus.b_val);
    lt_p0    = bus.funct3[1] ? (bus.a_val < bus.b_val) : (a_s_p0 < b_s_p0);
    legal_p0 = (bus.funct3[2:1] != 2'b01);
    // funct3[0] inverts the base condition (BNE/BGE/BGEU)
    taken_p0 = legal_p0 & ((bus.funct3[2] ? lt_p0 : eq_p0) ^ bus.funct3[0]);
  end

  // Presented result, either from the p1 register or straight from p0
  logic vld_o;
  logic eq_o;
  logic lt_o;
  logic taken_o;
  logic pred_o;
  logic ill_o;

  generate
    if (REG_OUT != 0) begin : g_reg
      // Stage p1: result register; flush beats stall, stall freezes all fields
      logic vld_p1;
      logic eq_p1;
      logic lt_p1;
      logic taken_p1;
      logic pred_p1;
      logic ill_p1;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1   <= 1'b0;
          eq_p1    <= 1'b0;
          lt_p1    <= 1'b0;
          taken_p1 <= 1'b0;
          pred_p1  <= 1'b0;
          ill_p1   <= 1'b0;
        end else if (bus.flush) begin
          vld_p1   <= 1'b0;
        end else if (!bus.stall) begin
          vld_p1   <= bus.in_valid;
          eq_p1    <= eq_p0;
          lt_p1    <= lt_p0;
          taken_p1 <= taken_p0;
          pred_p1  <= bus.pred_taken;
          ill_p1   <= ~legal_p0;
        end
      end

      assign vld_o   = vld_p1;
      assign eq_o    = eq_p1;
      assign lt_o    = lt_p1;
      assign taken_o = taken_p1;
      assign pred_o  = pred_p1;
      assign ill_o   = ill_p1;
    end else begin : g_comb
      assign vld_o   = bus.in_valid & ~bus.flush;
      assign eq_o    = eq_p0;
      assign lt_o    = lt_p0;
      assign taken_o = taken_p0;
      assign pred_o  = bus.pred_taken;
      assign ill_o   = ~legal_p0;
    end
  endgenerate

  // Qualify every flag with out_valid so idle cycles present all zeros
  logic misp_o;
  assign misp_o         = vld_o & ~ill_o & (taken_o ^ pred_o);

  assign bus.out_valid  = vld_o;
  assign bus.br_eq      = vld_o & eq_o;
  assign bus.br_lt      = vld_o & lt_o;
  assign bus.taken      = vld_o & taken_o;
  assign bus.mispredict = misp_o;
  assign bus.illegal    = vld_o & ill_o;

  // Retire stage: counters advance on the cycle the result leaves the unit
  logic             retire;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  assign retire = vld_o & ~bus.stall & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (retire && !ill_o) begin
      br_cnt <= sat_inc(br_cnt);
      if (misp_o) begin
        mp_cnt <= sat_inc(mp_cnt);
      end
    end
  end

  assign bus.br_count      = br_cnt;
  assign bus.mispred_count = mp_cnt;

endmodule

// File: tb/tb_bcmp_pipe.sv
module tb_bcmp_pipe;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcmp_pipe_if #(.WIDTH(32), .CNT_W(32)) if0 ();
  bcmp_pipe_if #(.WIDTH(32), .CNT_W(3))  if1 ();
  bcmp_pipe_if #(.WIDTH(8),  .CNT_W(32)) if2 ();

  bcmp_pipe #(.WIDTH(32), .REG_OUT(1), .CNT_W(32)) u0 (.clk(clk), .rst(rst), .bus(if0));
  bcmp_pipe #(.WIDTH(32), .REG_OUT(1), .CNT_W(3))  u1 (.clk(clk), .rst(rst), .bus(if1));
  bcmp_pipe #(.WIDTH(8),  .REG_OUT(0), .CNT_W(32)) u2 (.clk(clk), .rst(rst), .bus(if2));

  // {out_valid, br_eq, br_lt, taken, mispredict, illegal}
  logic [5:0] obs0, obs1, obs2;
  assign obs0 = {if0.out_valid, if0.br_eq, if0.br_lt, if0.taken, if0.mispredict, if0.illegal};
  assign obs1 = {if1.out_valid, if1.br_eq, if1.br_lt, if1.taken, if1.mispredict, if1.illegal};
  assign obs2 = {if2.out_valid, if2.br_eq, if2.br_lt, if2.taken, if2.mispredict, if2.illegal};

  int n_chk = 0;
  int n_fail = 0;
  logic [5:0]  sb[$];
  logic [5:0]  exp_v;
  logic [31:0] exp_br, exp_mp;

  // RISC-V branch truth table for a 32-bit operand pair
  function automatic logic [5:0] model(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b, input logic pred);
    logic eq, lt, tk, ill;
    eq  = (a == b);
    lt  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    tk  = 1'b0;
    ill = 1'b0;
    case (f3)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default:        ill = 1'b1;
    endcase
    return {1'b1, eq, lt, tk, (!ill && (tk != pred)), ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic p);
    if0.in_valid = v; if0.funct3 = f3; if0.a_val = a; if0.b_val = b; if0.pred_taken = p;
  endtask

  task automatic drive1(input logic v, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic p);
    if1.in_valid = v; if1.funct3 = f3; if1.a_val = a; if1.b_val = b; if1.pred_taken = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (obs0 !== 6'b0) begin
      n_fail++; $display("FAIL reset_out0 got=%b want=%b", obs0, 6'b0);
    end
    n_chk++;
    if (if0.br_count !== 32'd0 || if0.mispred_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt0 got=%0d/%0d want=0/0", if0.br_count, if0.mispred_count);
    end
    n_chk++;
    if (obs2 !== 6'b0 || if1.br_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_other got=%b/%0d want=000000/0", obs2, if1.br_count);
    end
    rst = 1'b0;
    exp_br = 0;
    exp_mp = 0;
  endtask

  task automatic test_blt();
    logic [2:0] f3s[2];
    f3s[0] = 3'b100;
    f3s[1] = 3'b110;
    for (int i = 0; i < 2; i++) begin
      drive0(1'b1, f3s[i], 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      sb.push_back(model(f3s[i], 32'hFFFF_FFFF, 32'h0000_0001, 1'b0));
      tick();
      drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      exp_v = sb.pop_front();
      n_chk++;
      if (obs0 !== exp_v) begin
        n_fail++; $display("FAIL blt_out[%0d] got=%b want=%b", i, obs0, exp_v);
      end
      exp_br += 32'(!exp_v[0]);
      exp_mp += 32'(exp_v[1]);
      tick();
      n_chk++;
      if (if0.br_count !== exp_br || if0.mispred_count !== exp_mp) begin
        n_fail++; $display("FAIL blt_cnt[%0d] got=%0d/%0d want=%0d/%0d", i,
                           if0.br_count, if0.mispred_count, exp_br, exp_mp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [2:0]  f3s[6];
    logic [31:0] as[2], bs[2];
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b100;
    f3s[3] = 3'b101; f3s[4] = 3'b110; f3s[5] = 3'b111;
    as[0] = 32'd5; bs[0] = 32'd5;
    as[1] = 32'd3; bs[1] = 32'd7;
    // back-to-back: one new branch every cycle
    for (int k = 0; k < 12; k++) begin
      drive0(1'b1, f3s[k % 6], as[k / 6], bs[k / 6], k[0]);
      sb.push_back(model(f3s[k % 6], as[k / 6], bs[k / 6], k[0]));
      tick();
      n_chk++;
      if (if0.br_count !== exp_br || if0.mispred_count !== exp_mp) begin
        n_fail++; $display("FAIL sweep_cnt[%0d] got=%0d/%0d want=%0d/%0d", k,
                           if0.br_count, if0.mispred_count, exp_br, exp_mp);
      end
      exp_v = sb.pop_front();
      n_chk++;
      if (obs0 !== exp_v) begin
        n_fail++; $display("FAIL sweep_out[%0d] got=%b want=%b", k, obs0, exp_v);
      end
      exp_br += 32'(!exp_v[0]);
      exp_mp += 32'(exp_v[1]);
    end
    // illegal funct3
    drive0(1'b1, 3'b010, 32'd5, 32'd5, 1'b1);
    sb.push_back(model(3'b010, 32'd5, 32'd5, 1'b1));
    tick();
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    exp_v = sb.pop_front();
    n_chk++;
    if (obs0 !== exp_v) begin
      n_fail++; $display("FAIL illegal_out got=%b want=%b", obs0, exp_v);
    end
    tick();
    n_chk++;
    if (if0.br_count !== exp_br || if0.mispred_count !== exp_mp) begin
      n_fail++; $display("FAIL illegal_cnt got=%0d/%0d want=%0d/%0d",
                         if0.br_count, if0.mispred_count, exp_br, exp_mp);
    end
  endtask

  task automatic test_stall();
    drive0(1'b1, 3'b000, 32'd9, 32'd9, 1'b1);
    sb.push_back(model(3'b000, 32'd9, 32'd9, 1'b1));
    tick();
    exp_v = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      if0.stall = 1'b1;
      drive0(1'b1, 3'b000, 32'd1, 32'd2, 1'b0);
      n_chk++;
      if (obs0 !== exp_v) begin
        n_fail++; $display("FAIL stall_out[%0d] got=%b want=%b", k, obs0, exp_v);
      end
      n_chk++;
      if (if0.br_count !== exp_br || if0.mispred_count !== exp_mp) begin
        n_fail++; $display("FAIL stall_cnt[%0d] got=%0d/%0d want=%0d/%0d", k,
                           if0.br_count, if0.mispred_count, exp_br, exp_mp);
      end
      tick();
    end
    if0.stall = 1'b0;
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    n_chk++;
    if (obs0 !== exp_v) begin
      n_fail++; $display("FAIL stall_release_out got=%b want=%b", obs0, exp_v);
    end
    exp_br += 32'(!exp_v[0]);
    exp_mp += 32'(exp_v[1]);
    tick();
    n_chk++;
    if (if0.br_count !== exp_br || if0.mispred_count !== exp_mp || if0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release_cnt got=%0d/%0d/v%b want=%0d/%0d/v0",
                         if0.br_count, if0.mispred_count, if0.out_valid, exp_br, exp_mp);
    end
  endtask

  task automatic test_flush_rst();
    drive0(1'b1, 3'b001, 32'd1, 32'd2, 1'b0);
    sb.push_back(model(3'b001, 32'd1, 32'd2, 1'b0));
    tick();
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    if0.stall = 1'b1;
    if0.flush = 1'b1;
    exp_v = sb.pop_front();
    n_chk++;
    if (obs0 !== exp_v) begin
      n_fail++; $display("FAIL flush_pre_out got=%b want=%b", obs0, exp_v);
    end
    tick();
    if0.stall = 1'b0;
    if0.flush = 1'b0;
    n_chk++;
    if (if0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid got=%b want=0", if0.out_valid);
    end
    n_chk++;
    if (if0.br_count !== exp_br || if0.mispred_count !== exp_mp) begin
      n_fail++; $display("FAIL flush_cnt got=%0d/%0d want=%0d/%0d",
                         if0.br_count, if0.mispred_count, exp_br, exp_mp);
    end
    // reset while a result is presented
    drive0(1'b1, 3'b000, 32'd4, 32'd4, 1'b0);
    sb.push_back(model(3'b000, 32'd4, 32'd4, 1'b0));
    tick();
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    exp_v = sb.pop_front();
    n_chk++;
    if (obs0 !== exp_v) begin
      n_fail++; $display("FAIL rst_pre_out got=%b want=%b", obs0, exp_v);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    n_chk++;
    if (obs0 !== 6'b0 || if0.br_count !== 32'd0 || if0.mispred_count !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid got=%b/%0d/%0d want=000000/0/0",
                         obs0, if0.br_count, if0.mispred_count);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 9; k++) begin
      drive1(1'b1, 3'b000, 32'd7, 32'd7, 1'b0);
      sb.push_back(model(3'b000, 32'd7, 32'd7, 1'b0));
      tick();
      exp_v = sb.pop_front();
      n_chk++;
      if (obs1 !== exp_v) begin
        n_fail++; $display("FAIL sat_out[%0d] got=%b want=%b", k, obs1, exp_v);
      end
    end
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    tick();
    n_chk++;
    if (if1.br_count !== 3'd7 || if1.mispred_count !== 3'd7) begin
      n_fail++; $display("FAIL sat_cnt got=%0d/%0d want=7/7", if1.br_count, if1.mispred_count);
    end
    // clear on the same cycle as a retire
    drive1(1'b1, 3'b000, 32'd7, 32'd7, 1'b0);
    sb.push_back(model(3'b000, 32'd7, 32'd7, 1'b0));
    tick();
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    exp_v = sb.pop_front();
    n_chk++;
    if (obs1 !== exp_v) begin
      n_fail++; $display("FAIL clr_out got=%b want=%b", obs1, exp_v);
    end
    if1.cnt_clr = 1'b1;
    tick();
    if1.cnt_clr = 1'b0;
    n_chk++;
    if (if1.br_count !== 3'd0 || if1.mispred_count !== 3'd0) begin
      n_fail++; $display("FAIL clr_cnt got=%0d/%0d want=0/0", if1.br_count, if1.mispred_count);
    end
    drive1(1'b1, 3'b000, 32'd7, 32'd7, 1'b0);
    tick();
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    tick();
    n_chk++;
    if (if1.br_count !== 3'd1 || if1.mispred_count !== 3'd1) begin
      n_fail++; $display("FAIL clr_resume got=%0d/%0d want=1/1", if1.br_count, if1.mispred_count);
    end
  endtask

  task automatic test_comb();
    if2.in_valid = 1'b1; if2.funct3 = 3'b101; if2.a_val = 8'h80; if2.b_val = 8'h7F;
    if2.pred_taken = 1'b0;
    #1;
    n_chk++;
    if (obs2 !== 6'b101000) begin
      n_fail++; $display("FAIL comb_bge got=%b want=101000", obs2);
    end
    tick();
    n_chk++;
    if (if2.br_count !== 32'd1 || if2.mispred_count !== 32'd0) begin
      n_fail++; $display("FAIL comb_bge_cnt got=%0d/%0d want=1/0", if2.br_count, if2.mispred_count);
    end
    if2.funct3 = 3'b111;
    #1;
    n_chk++;
    if (obs2 !== 6'b100110) begin
      n_fail++; $display("FAIL comb_bgeu got=%b want=100110", obs2);
    end
    tick();
    n_chk++;
    if (if2.br_count !== 32'd2 || if2.mispred_count !== 32'd1) begin
      n_fail++; $display("FAIL comb_bgeu_cnt got=%0d/%0d want=2/1", if2.br_count, if2.mispred_count);
    end
    if2.flush = 1'b1;
    #1;
    n_chk++;
    if ({if2.out_valid, if2.mispredict, if2.illegal} !== 3'b000) begin
      n_fail++; $display("FAIL comb_flush got=%b want=000",
                         {if2.out_valid, if2.mispredict, if2.illegal});
    end
    tick();
    if2.flush = 1'b0;
    if2.in_valid = 1'b0;
    n_chk++;
    if (if2.br_count !== 32'd2 || if2.mispred_count !== 32'd1) begin
      n_fail++; $display("FAIL comb_flush_cnt got=%0d/%0d want=2/1", if2.br_count, if2.mispred_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    if0.stall = 1'b0; if0.flush = 1'b0; if0.cnt_clr = 1'b0;
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    if1.stall = 1'b0; if1.flush = 1'b0; if1.cnt_clr = 1'b0;
    if2.in_valid = 1'b0; if2.funct3 = 3'b000; if2.a_val = 8'd0; if2.b_val = 8'd0;
    if2.pred_taken = 1'b0; if2.stall = 1'b0; if2.flush = 1'b0; if2.cnt_clr = 1'b0;
    #1;
    test_reset();
    test_blt();
    test_sweep();
    test_stall();
    test_flush_rst();
    test_saturate();
    test_comb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcmp_pipe.md
Name: bcmp_pipe

Overview:
Parametrised branch-resolution unit for the RISC-V core. It generalises the plain branch comparator in three ways:
- Decodes the full branch funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Adds an optional output register stage with stall/flush handshake.
- Flags mispredicts against the fetch-stage prediction and keeps saturating branch and mispredict counters for CSR perf readout.
Sits between the execute-stage operand muxes and the PC-select/flush logic.

Parameters:
WIDTH, 32, operand width in bits (>=2)
REG_OUT, 1, 1 = one registered stage (latency 1); 0 = combinational result (latency 0)
CNT_W, 32, width of each perf counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  a branch is present on the inputs this cycle
funct3  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
a_val  in  WIDTH  rs1 operand
b_val  in  WIDTH  rs2 operand
pred_taken  in  1  fetch-stage prediction for this branch
stall  in  1  downstream not accepting; hold result
flush  in  1  kill the in-flight/presented branch
cnt_clr  in  1  synchronous clear of both counters
out_valid  out  1  result valid
br_eq  out  1  a_val == b_val
br_lt  out  1  a < b, signed or unsigned per funct3[1]
taken  out  1  branch condition true
mispredict  out  1  out_valid & legal & (taken != pred_taken)
illegal  out  1  out_valid & funct3 in {010, 011}
br_count  out  CNT_W  retired legal branches
mispred_count  out  CNT_W  retired mispredicted branches

Behaviour:
- Compare:
  - br_eq = a==b.
  - br_lt uses unsigned compare when funct3[1]=1, else signed two's-complement, full WIDTH.
  - Base condition: funct3[2]=0 -> eq; funct3[2]=1 -> lt. taken = base XOR funct3[0].
  - Illegal funct3 (010/011): taken=0, mispredict=0, illegal=1.
- REG_OUT=1:
  - One register stage holds br_eq, br_lt, taken, pred_taken, the illegal flag and the valid bit.
  - Load rule, in priority order:
    1. rst -> all zero.
    2. flush -> valid register cleared next cycle; stall is ignored.
    3. stall -> register holds all fields.
    4. else -> register loads in_valid & inputs.
  - Upstream must hold its inputs while stall=1. Inputs are ignored during stall.
  - Result appears the cycle after acceptance.
- REG_OUT=0:
  - Outputs are combinational from the inputs; out_valid = in_valid & ~flush.
  - stall has no effect on the data path.
- Output qualification: br_eq/br_lt/taken are meaningful only when out_valid=1. When out_valid=0, mispredict and illegal are 0.
- Retire event: out_valid & ~stall & ~flush, evaluated in the same cycle the result is presented.
- Counters:
  - On a retire with legal funct3, br_count increments.
  - If that retire also has mispredict=1, mispred_count increments.
  - Both counters saturate at all-ones (no wrap).
  - cnt_clr zeroes both counters next cycle and has priority over a simultaneous increment.
  - Counters are also cleared by rst.
- Reset values: out_valid=0, br_eq=0, br_lt=0, taken=0, mispredict=0, illegal=0, br_count=0, mispred_count=0.
- Reset mid-operation: any in-flight result is discarded. No retire is counted on the reset cycle.
- Stall and flush together: flush wins. The result is dropped and not counted.
- Back-to-back branches with stall low: one result per cycle; counters can increment every cycle.

Test Plan:
1. REG_OUT=1, WIDTH=32. Drive BLT with a=0xFFFFFFFF, b=0x00000001, pred_taken=0 -> next cycle: out_valid=1, taken=1, br_lt=1, mispredict=1; br_count=1 and mispred_count=1 one cycle later. Repeat as BLTU -> taken=0, mispredict=0.
2. Sweep all six legal funct3 values with a=b=5, then a=3/b=7 -> taken matches the ISA truth table. Drive funct3=010 -> illegal=1, taken=0, counters unchanged.
3. Accept a BEQ (a=b) with pred_taken=1, then hold stall=1 for 3 cycles while the inputs change to a!=b -> outputs frozen at taken=1, out_valid=1, no counter increment while stalled; the count increments once when stall drops.
4. Stall=1 and flush=1 in the same cycle with a valid result -> out_valid=0 next cycle, counters unchanged. Assert rst while out_valid=1 -> all outputs and counters 0 next cycle.
5. CNT_W=3. Retire 9 mispredicted branches back-to-back -> br_count and mispred_count saturate at 7. Assert cnt_clr on the same cycle as a retire -> both counters 0.
6. REG_OUT=0, WIDTH=8. a=0x80, b=0x7F, BGE -> same-cycle taken=0; BGEU -> taken=1; flush=1 -> out_valid=0 combinationally.
